amo_unit: RTL and testbench
===========================

Name: amo_unit

Overview:
Multi-cycle atomic memory operation engine for RV32A instructions (LR.W, SC.W, AMO*.W).
- Consumes the amo_wr_en / amoop micro-op emitted by instruction decode, plus the effective address and rs2 operand.
- Runs the read-modify-write sequence on the data-memory port and returns the old memory word for register writeback.
- Holds the pipeline stalled via busy, and owns the single LR/SC reservation.

Parameters:
XLEN, 32, data and address width
RSV_GRAN, 2, reservation granule as log2 bytes; address bits [XLEN-1:RSV_GRAN] are compared

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  launch the AMO (amo_wr_en qualified by a valid instruction); sampled only in IDLE
amoop  in  amoop_t  operation: AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD, AMO_XOR, AMO_AND, AMO_OR, AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU
addr  in  XLEN  effective address (rs1)
rs2_data  in  XLEN  operand / store data
busy  out  1  high whenever state != IDLE; stalls the pipeline
done  out  1  one-cycle pulse when the result is valid
rd_data  out  XLEN  writeback value, valid while done=1
misaligned  out  1  one-cycle pulse with done when addr[1:0] != 0
mem_req  out  1  memory request, held until mem_gnt
mem_we  out  1  1 = write, 0 = read
mem_addr  out  XLEN  word address {addr[XLEN-1:2],2'b00}
mem_wdata  out  XLEN  write data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid, no earlier than 1 cycle after the read gnt
mem_rdata  in  XLEN  read data
snoop_st  in  1  a store from the LSU or another master completed this cycle
snoop_addr  in  XLEN  address of that store

Behaviour:
Reset (asynchronous, takes effect immediately):
- State = IDLE; reservation invalid.
- All outputs are 0: busy, done, misaligned, mem_req, mem_we, mem_addr, mem_wdata, rd_data.
- Reset in the middle of an operation drops mem_req at once; any in-flight rvalid is ignored afterwards.

Latching at start:
- In IDLE, start=1 latches amoop, addr and rs2_data.
- start while busy is ignored.

FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE -> DONE when start and addr[1:0] != 0: misaligned=1, rd_data=0, no memory access, reservation unchanged.
- IDLE -> DONE for AMO_SC with no reservation hit: rd_data=1, no memory access.
- IDLE -> WR_REQ for AMO_SC with a reservation hit: mem_wdata=rs2_data.
- IDLE -> RD_REQ for all other ops.
- Any SC clears the reservation when it leaves IDLE, whether it succeeds or fails.
- RD_REQ: mem_req=1, mem_we=0. On mem_gnt -> RD_WAIT.
- RD_WAIT: on mem_rvalid, capture old=mem_rdata.
  - AMO_LR -> DONE and set the reservation {valid=1, addr}.
  - Otherwise compute new and -> WR_REQ.
- WR_REQ: mem_req=1, mem_we=1, mem_wdata=new (rs2_data for SC). On mem_gnt -> DONE.
- DONE: done=1 for exactly one cycle.
  - rd_data = old for LR and AMO ops; 0 for a successful SC; 1 for a failed SC.
  - Next state is IDLE.
  - A start in the DONE cycle is ignored; the earliest accepted start is the following cycle.

mem_req / mem_addr / mem_wdata / mem_we are stable while mem_req=1 and mem_gnt=0.

Modify function, XLEN-bit, wrap-around, no flags:
- SWAP: rs2
- ADD: old+rs2
- XOR, AND, OR: bitwise
- MIN / MAX: signed compare
- MINU / MAXU: unsigned compare

Reservation:
- Hit = valid && addr[XLEN-1:RSV_GRAN] == rsv_addr[XLEN-1:RSV_GRAN].
- snoop_st with a matching granule clears valid.
- Our own AMO write completing on a matching granule also clears valid.
- Simultaneous LR set and snoop clear in the same cycle: the snoop wins (valid=0).
- A new LR overwrites the old reservation.

Minimum latency, 1-cycle gnt and rvalid:
- Read-modify-write: done 4 cycles after start (RD_REQ, RD_WAIT, WR_REQ, DONE).
- LR: done 3 cycles after start.
- Failed SC or misaligned: done 1 cycle after start.

Test Plan:
- AMO_ADD: mem[0x100]=5, rs2=3, gnt and rvalid 1-cycle -> one read of 0x100, then a write of 8 to 0x100; done with rd_data=5 at start+4; busy high cycles 1-4.
- Signed vs unsigned: mem=0xFFFFFFFF, rs2=1.
  - AMO_MIN writes 0xFFFFFFFF; AMO_MAXU writes 0xFFFFFFFF.
  - AMO_MINU writes 0x00000001; AMO_MAX writes 0x00000001.
  - rd_data=0xFFFFFFFF in every case.
- LR/SC pairs:
  - LR 0x200 (mem=7) -> rd_data=7. Then SC 0x200, rs2=9 -> write 9, rd_data=0.
  - A second SC 0x200 -> no mem_req, rd_data=1.
- Reservation break by snoop: LR 0x200, then snoop_st at 0x202 -> SC 0x200 fails (rd_data=1, no write).
  - Repeat with snoop at 0x204 -> SC succeeds.
- Misaligned and backpressure:
  - AMO_SWAP at 0x101 -> misaligned=1, done at start+1, mem_req never asserted.
  - AMO_SWAP at 0x100 with mem_gnt held low 3 cycles -> mem_req/addr stable throughout, completes after gnt.
- Reset mid-operation: assert rst in RD_WAIT -> mem_req, busy and done go 0 immediately; a later rvalid produces no done.
  - A subsequent SC fails (reservation cleared).

Source files
------------

// File: rtl/amo_unit.sv
// RV32A atomic memory operation engine: LR.W / SC.W / AMO*.W read-modify-write
// sequencer on a single data-memory port, owning the LR/SC reservation.

package amo_pkg;
    typedef enum logic [3:0] {
        AMO_LR,
        AMO_SC,
        AMO_SWAP,
        AMO_ADD,
        AMO_XOR,
        AMO_AND,
        AMO_OR,
        AMO_MIN,
        AMO_MAX,
        AMO_MINU,
        AMO_MAXU
    } amoop_t;
endpackage

// state   | meaning
// IDLE    | waiting for start; decodes misaligned / SC outcome
// RD_REQ  | read request outstanding until mem_gnt
// RD_WAIT | read granted, waiting for mem_rvalid
// WR_REQ  | write request outstanding until mem_gnt
// DONE    | one-cycle result pulse, back to IDLE
module amo_unit
    import amo_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RSV_GRAN = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  amoop_t          amoop,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] rs2_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rd_data,
    output logic            misaligned,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            snoop_st,
    input  logic [XLEN-1:0] snoop_addr
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DONE
    } state_t;

    state_t          state, state_nx;
    amoop_t          op_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] wdata_q, wdata_nx;
    logic [XLEN-1:0] res_q, res_nx;
    logic            mis_q, mis_nx;
    logic [XLEN-1:0] new_val;

    logic            rsv_valid;
    logic [XLEN-1:0] rsv_addr;
    logic            rsv_hit;
    logic            rsv_set;
    logic            rsv_sc_clr;
    logic [XLEN-1:0] rsv_tgt;
    logic            snoop_hit;
    logic            own_wr_hit;

    // Only the granule bits take part in reservation matching.
    logic            unused_bits;
    assign unused_bits = ^{addr_q[RSV_GRAN-1:0], rsv_addr[RSV_GRAN-1:0],
                           snoop_addr[RSV_GRAN-1:0]};

    assign rsv_hit = rsv_valid &&
                     (addr[XLEN-1:RSV_GRAN] == rsv_addr[XLEN-1:RSV_GRAN]);

    always_comb begin
        new_val = rs2_q;
        case (op_q)
            AMO_ADD:  new_val = mem_rdata + rs2_q;
            AMO_XOR:  new_val = mem_rdata ^ rs2_q;
            AMO_AND:  new_val = mem_rdata & rs2_q;
            AMO_OR:   new_val = mem_rdata | rs2_q;
            AMO_MIN:  new_val = ($signed(mem_rdata) < $signed(rs2_q)) ? mem_rdata : rs2_q;
            AMO_MAX:  new_val = ($signed(mem_rdata) > $signed(rs2_q)) ? mem_rdata : rs2_q;
            AMO_MINU: new_val = (mem_rdata < rs2_q) ? mem_rdata : rs2_q;
            AMO_MAXU: new_val = (mem_rdata > rs2_q) ? mem_rdata : rs2_q;
            default:  new_val = rs2_q;
        endcase
    end

    always_comb begin
        state_nx   = state;
        wdata_nx   = wdata_q;
        res_nx     = res_q;
        mis_nx     = mis_q;
        rsv_set    = 1'b0;
        rsv_sc_clr = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    mis_nx = 1'b0;
                    if (addr[1:0] != 2'b00) begin
                        mis_nx   = 1'b1;
                        res_nx   = '0;
                        state_nx = DONE;
                    end else if (amoop == AMO_SC) begin
                        rsv_sc_clr = 1'b1;
                        if (rsv_hit) begin
                            wdata_nx = rs2_data;
                            res_nx   = '0;
                            state_nx = WR_REQ;
                        end else begin
                            res_nx   = XLEN'(1);
                            state_nx = DONE;
                        end
                    end else begin
                        state_nx = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (mem_gnt) state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    res_nx = mem_rdata;
                    if (op_q == AMO_LR) begin
                        rsv_set  = 1'b1;
                        state_nx = DONE;
                    end else begin
                        wdata_nx = new_val;
                        state_nx = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (mem_gnt) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= AMO_LR;
            addr_q  <= '0;
            rs2_q   <= '0;
            wdata_q <= '0;
            res_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            wdata_q <= wdata_nx;
            res_q   <= res_nx;
            mis_q   <= mis_nx;
            if (state == IDLE && start) begin
                op_q   <= amoop;
                addr_q <= addr;
                rs2_q  <= rs2_data;
            end
        end
    end

    // A snoop landing in the same cycle an LR sets the reservation must be
    // compared against the address being reserved, not the stale one.
    assign rsv_tgt    = rsv_set ? addr_q : rsv_addr;
    assign snoop_hit  = snoop_st &&
                        (snoop_addr[XLEN-1:RSV_GRAN] == rsv_tgt[XLEN-1:RSV_GRAN]);
    assign own_wr_hit = (state == WR_REQ) && mem_gnt &&
                        (addr_q[XLEN-1:RSV_GRAN] == rsv_addr[XLEN-1:RSV_GRAN]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsv_valid <= 1'b0;
            rsv_addr  <= '0;
        end else if (rsv_set) begin
            rsv_addr  <= addr_q;
            rsv_valid <= !snoop_hit;
        end else if (rsv_sc_clr || snoop_hit || own_wr_hit) begin
            rsv_valid <= 1'b0;
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign misaligned = done && mis_q;
    assign rd_data    = done ? res_q : '0;
    assign mem_req    = (state == RD_REQ) || (state == WR_REQ);
    assign mem_we     = (state == WR_REQ);
    assign mem_addr   = {addr_q[XLEN-1:2], 2'b00};
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_amo_unit.sv
// Directed bench for amo_unit with a small word memory answering the port.
module tb_amo_unit;
    import amo_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    amoop_t      amoop;
    logic [31:0] addr;
    logic [31:0] rs2_data;
    logic        busy;
    logic        done;
    logic [31:0] rd_data;
    logic        misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        snoop_st;
    logic [31:0] snoop_addr;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:255];

    logic [31:0] r_rd, r_waddr, r_wdata, r_raddr;
    logic        r_mis, r_stable, r_busy_ok, r_timeout;
    int          r_cyc, r_req_cycles, r_rd_cnt, r_wr_cnt;

    typedef struct {
        amoop_t      op;
        logic [31:0] init;
        logic [31:0] rs2;
        logic [31:0] exp_w;
    } vec_t;
    vec_t vecs [8];

    amo_unit #(.XLEN(32), .RSV_GRAN(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .amoop      (amoop),
        .addr       (addr),
        .rs2_data   (rs2_data),
        .busy       (busy),
        .done       (done),
        .rd_data    (rd_data),
        .misaligned (misaligned),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .snoop_st   (snoop_st),
        .snoop_addr (snoop_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one op and act as memory: gnt after lat stall cycles, rvalid one
    // cycle after a read gnt. Outputs are sampled on the falling edge.
    task automatic run_op(input string tag, input amoop_t op, input logic [31:0] a,
                          input logic [31:0] d, input int lat);
        int          wait_cnt;
        logic        rd_granted, p_req, p_gnt, p_we;
        logic [31:0] p_addr, p_wdata, rd_word;
        r_rd = '0; r_mis = 1'b0; r_cyc = 0; r_req_cycles = 0; r_rd_cnt = 0; r_wr_cnt = 0;
        r_waddr = '0; r_wdata = '0; r_raddr = '0;
        r_stable = 1'b1; r_busy_ok = 1'b1; r_timeout = 1'b1;
        wait_cnt = 0; rd_granted = 1'b0; p_req = 1'b0; p_gnt = 1'b0; p_we = 1'b0;
        p_addr = '0; p_wdata = '0; rd_word = '0;
        @(negedge clk);
        start = 1'b1; amoop = op; addr = a; rs2_data = d;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
            if (!busy) r_busy_ok = 1'b0;
            if (done) begin
                r_rd = rd_data; r_mis = misaligned; r_cyc = c; r_timeout = 1'b0;
                break;
            end
            if (rd_granted) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem[rd_word[9:2]];
                rd_granted = 1'b0;
            end
            if (mem_req) begin
                r_req_cycles++;
                if (p_req && !p_gnt &&
                    (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
                    r_stable = 1'b0;
                if (wait_cnt < lat) begin
                    wait_cnt++;
                end else begin
                    mem_gnt  = 1'b1;
                    wait_cnt = 0;
                    if (mem_we) begin
                        r_wr_cnt++;
                        r_waddr = mem_addr;
                        r_wdata = mem_wdata;
                        mem[mem_addr[9:2]] = mem_wdata;
                    end else begin
                        r_rd_cnt++;
                        r_raddr    = mem_addr;
                        rd_word    = mem_addr;
                        rd_granted = 1'b1;
                    end
                end
            end
            p_req = mem_req; p_gnt = mem_gnt; p_we = mem_we;
            p_addr = mem_addr; p_wdata = mem_wdata;
            @(negedge clk);
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk({tag, "_timeout"}, {31'd0, r_timeout}, 32'd0);
    endtask

    task automatic snoop_pulse(input logic [31:0] a);
        @(negedge clk);
        snoop_st = 1'b1; snoop_addr = a;
        @(negedge clk);
        snoop_st = 1'b0; snoop_addr = '0;
    endtask

    initial begin
        logic saw_done;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h40] = 32'd5;   // 0x100
        mem[8'h80] = 32'd7;   // 0x200

        vecs[0] = '{AMO_MIN,  32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF};
        vecs[1] = '{AMO_MAXU, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF};
        vecs[2] = '{AMO_MINU, 32'hFFFF_FFFF, 32'h1,         32'h0000_0001};
        vecs[3] = '{AMO_MAX,  32'hFFFF_FFFF, 32'h1,         32'h0000_0001};
        vecs[4] = '{AMO_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0000_0000};
        vecs[5] = '{AMO_XOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0};
        vecs[6] = '{AMO_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F};
        vecs[7] = '{AMO_OR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF};

        rst = 1'b1; start = 1'b0; amoop = AMO_LR; addr = '0; rs2_data = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        snoop_st = 1'b0; snoop_addr = '0;

        #1;
        chk("reset_ctrl", {27'd0, busy, done, misaligned, mem_req, mem_we}, 32'd0);
        chk("reset_addr", mem_addr, 32'd0);
        chk("reset_wdata", mem_wdata, 32'd0);
        chk("reset_rd", rd_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("add", AMO_ADD, 32'h100, 32'd3, 0);
        chk("add_rd", r_rd, 32'd5);
        chk("add_lat", r_cyc, 32'd4);
        chk("add_rdaddr", r_raddr, 32'h100);
        chk("add_counts", {r_rd_cnt[15:0], r_wr_cnt[15:0]}, {16'd1, 16'd1});
        chk("add_waddr", r_waddr, 32'h100);
        chk("add_wdata", r_wdata, 32'd8);
        chk("add_busy", {31'd0, r_busy_ok}, 32'd1);
        chk("add_mis", {31'd0, r_mis}, 32'd0);
        @(negedge clk);
        chk("add_idle_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            mem[8'h60] = vecs[i].init;   // 0x180
            run_op("alu", vecs[i].op, 32'h180, vecs[i].rs2, 0);
            chk($sformatf("alu%0d_wdata", i), r_wdata, vecs[i].exp_w);
            chk($sformatf("alu%0d_rd", i), r_rd, vecs[i].init);
        end

        run_op("lr1", AMO_LR, 32'h200, 32'd0, 0);
        chk("lr1_rd", r_rd, 32'd7);
        chk("lr1_lat", r_cyc, 32'd3);
        chk("lr1_wr", r_wr_cnt, 32'd0);
        run_op("sc1", AMO_SC, 32'h200, 32'd9, 0);
        chk("sc1_rd", r_rd, 32'd0);
        chk("sc1_counts", {r_rd_cnt[15:0], r_wr_cnt[15:0]}, {16'd0, 16'd1});
        chk("sc1_wdata", r_wdata, 32'd9);
        chk("sc1_waddr", r_waddr, 32'h200);
        run_op("sc2", AMO_SC, 32'h200, 32'd10, 0);
        chk("sc2_rd", r_rd, 32'd1);
        chk("sc2_req", r_req_cycles, 32'd0);
        chk("sc2_lat", r_cyc, 32'd1);

        run_op("lr2", AMO_LR, 32'h200, 32'd0, 0);
        chk("lr2_rd", r_rd, 32'd9);
        snoop_pulse(32'h202);
        run_op("sc3", AMO_SC, 32'h200, 32'h11, 0);
        chk("sc3_rd", r_rd, 32'd1);
        chk("sc3_req", r_req_cycles, 32'd0);

        run_op("lr3", AMO_LR, 32'h200, 32'd0, 0);
        snoop_pulse(32'h204);
        run_op("sc4", AMO_SC, 32'h200, 32'h22, 0);
        chk("sc4_rd", r_rd, 32'd0);
        chk("sc4_wdata", r_wdata, 32'h22);

        run_op("mis", AMO_SWAP, 32'h101, 32'hA5, 0);
        chk("mis_flag", {31'd0, r_mis}, 32'd1);
        chk("mis_lat", r_cyc, 32'd1);
        chk("mis_rd", r_rd, 32'd0);
        chk("mis_req", r_req_cycles, 32'd0);

        run_op("bp", AMO_SWAP, 32'h100, 32'hA5, 3);
        chk("bp_rd", r_rd, 32'd8);
        chk("bp_stable", {31'd0, r_stable}, 32'd1);
        chk("bp_wdata", r_wdata, 32'hA5);
        chk("bp_lat", r_cyc, 32'd10);
        chk("bp_req", r_req_cycles, 32'd8);

        run_op("lr4", AMO_LR, 32'h200, 32'd0, 0);
        chk("lr4_rd", r_rd, 32'h22);
        @(negedge clk);
        start = 1'b1; amoop = AMO_ADD; addr = 32'h300; rs2_data = 32'd1;
        @(negedge clk);
        start = 1'b0;
        chk("rst_pre_req", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid", {29'd0, mem_req, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h55;
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1 if (done || busy) saw_done = 1'b1;
        end
        mem_rvalid = 1'b0; mem_rdata = '0;
        chk("rst_no_done", {31'd0, saw_done}, 32'd0);
        run_op("sc5", AMO_SC, 32'h200, 32'd1, 0);
        chk("sc5_rd", r_rd, 32'd1);
        chk("sc5_req", r_req_cycles, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
